// File: rtl/mac_host_seq.sv
// mac_host_seq: host-side sequencer for a tiny MAC. It clears the MAC, issues one accumulate per operand pair,
// turns the shared B/high-byte bus around and returns the 16-bit accumulator as one result per job.
module mac_host_seq #(
  parameter int LEN      = 4,
  parameter int TURN_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        mac_rst_n,
  output logic        mac_ena,
  output logic [7:0]  mac_a,
  output logic [7:0]  mac_b,
  output logic        mac_b_oe,
  input  logic [7:0]  mac_low,
  input  logic [7:0]  mac_high,
  output logic        busy
);
  localparam int CW = $clog2(LEN + 1);
  localparam int TW = $clog2(TURN_CYC + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, ACC, DRAIN, TURN, CAPTURE, HOLD} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [TW-1:0]   r_turn;
  logic            w_hs;
  assign w_hs = op_valid & op_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_turn    <= '0;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      mac_rst_n <= 1'b0;
      mac_ena   <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_b_oe  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          mac_rst_n <= 1'b1;
          if (op_valid) begin
            r_state   <= CLEAR;
            mac_rst_n <= 1'b0;
            mac_b_oe  <= 1'b1;
            mac_b     <= '0;
            busy      <= 1'b1;
          end
        end
        CLEAR: begin
          r_state   <= ACC;
          mac_rst_n <= 1'b1;
          op_ready  <= 1'b1;
          r_cnt     <= '0;
        end
        ACC: begin
          mac_ena <= w_hs;
          if (w_hs) begin
            mac_a <= op_a;
            mac_b <= op_b;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(LEN - 1)) begin
              op_ready <= 1'b0;
              r_state  <= DRAIN;
            end
          end
        end
        // last pulse is on the pins now; release the bus for the MAC high byte
        DRAIN: begin
          r_state  <= TURN;
          mac_ena  <= 1'b0;
          mac_b_oe <= 1'b0;
          mac_b    <= '0;
          r_turn   <= '0;
        end
        TURN: begin
          r_turn <= r_turn + TW'(1);
          if (r_turn == TW'(TURN_CYC - 1)) r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_state   <= HOLD;
          res_data  <= {mac_high, mac_low};
          res_valid <= 1'b1;
        end
        HOLD: begin
          if (res_ready) begin
            r_state   <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_host_seq.sv
// tb_mac_host_seq: table-driven jobs against three sequencer configurations, each wired to a behavioural MAC.
module tb_mac_host_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] ov = '0, rr = '1, ordy, rv, mrn, me, moe, bsy;
  logic [7:0] oa[3], ob[3], ma[3], mb[3], ml[3], mh[3];
  logic [15:0] rd[3];
  int total = 0, bad = 0;
  // unit 0: LEN=4/TURN=1, unit 1: LEN=4/TURN=3, unit 2: LEN=1/TURN=1
  for (genvar g = 0; g < 3; g++) begin : gi
    logic [15:0] acc;
    logic drv;
    mac_host_seq #(.LEN(g == 2 ? 1 : 4), .TURN_CYC(g == 1 ? 3 : 1)) u (
      .clk(clk), .rst(rst), .op_valid(ov[g]), .op_ready(ordy[g]), .op_a(oa[g]), .op_b(ob[g]),
      .res_valid(rv[g]), .res_ready(rr[g]), .res_data(rd[g]), .mac_rst_n(mrn[g]), .mac_ena(me[g]),
      .mac_a(ma[g]), .mac_b(mb[g]), .mac_b_oe(moe[g]), .mac_low(ml[g]), .mac_high(mh[g]), .busy(bsy[g]));
    always @(posedge clk or negedge mrn[g])
      if (!mrn[g]) acc <= '0;
      else if (me[g]) acc <= acc + 16'(ma[g]) * 16'(mb[g]);
    always @(posedge clk) drv <= ~moe[g];
    assign ml[g] = acc[7:0];
    assign mh[g] = (drv && !moe[g]) ? acc[15:8] : 8'h00;
  end
  typedef struct {
    int          d;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    bit          bub;
    int          hold;
    logic [15:0] exp;
  } vec_t;
  vec_t tv[7];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic chk_rst(input string nm);
    for (int d = 0; d < 3; d++)
      chk(nm, {ordy[d], rv[d], rd[d], mrn[d], me[d], ma[d], mb[d], moe[d], bsy[d]}, 64'd0);
  endtask
  task automatic run_job(input int i);
    vec_t j;
    int d, t, cyc, k, ena, nooe, clr, zr, lh, rc;
    j = tv[i]; d = j.d; t = (d == 1) ? 3 : 1;
    cyc = 0; k = 0; ena = 0; nooe = 0; clr = 0; zr = 0; lh = -1; rc = -1;
    rr[d] = (j.hold == 0);
    while (rc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (me[d]) ena++;
      if (me[d] && !moe[d]) nooe++;
      if (!mrn[d] && bsy[d]) clr++;
      if (lh >= 0 && !moe[d] && !rv[d]) zr++;
      if (rv[d]) rc = cyc;
      else begin
        ov[d] = (k < j.n) && (!j.bub || cyc[0]);
        oa[d] = j.a[8*(k%4) +: 8];
        ob[d] = j.b[8*(k%4) +: 8];
        if (ov[d] && ordy[d]) begin
          k++;
          lh = cyc;
        end
      end
    end
    ov[d] = 1'b0;
    $display("job %0d: res_data=%h after %0d cycles", i, rd[d], cyc);
    chk($sformatf("job%0d_done", i), 64'(rc >= 0), 64'd1);
    chk($sformatf("job%0d_data", i), 64'(rd[d]), 64'(j.exp));
    chk($sformatf("job%0d_pairs", i), 64'(k), 64'(j.n));
    chk($sformatf("job%0d_latency", i), 64'(rc - lh), 64'(t + 3));
    chk($sformatf("job%0d_ena", i), 64'(ena), 64'(j.n));
    chk($sformatf("job%0d_ena_oe", i), 64'(nooe), 64'd0);
    chk($sformatf("job%0d_clear", i), 64'(clr), 64'd1);
    chk($sformatf("job%0d_turn", i), 64'(zr), 64'(t + 1));
    if (j.hold > 0) begin
      ov[d] = 1'b1;
      repeat (j.hold) begin
        @(negedge clk);
        chk($sformatf("job%0d_hold", i), {rv[d], ordy[d], rd[d]}, {1'b1, 1'b0, j.exp});
      end
      ov[d] = 1'b0;
      rr[d] = 1'b1;
    end
    @(negedge clk);
    chk($sformatf("job%0d_idle", i), {rv[d], bsy[d]}, 64'd0);
  endtask
  initial begin
    int k, n;
    for (int d = 0; d < 3; d++) begin
      oa[d] = '0;
      ob[d] = '0;
    end
    tv[0] = '{0, 32'h07050301, 32'h08060402, 4, 1'b0, 0, 16'h0064};
    tv[1] = '{0, 32'h07050301, 32'h08060402, 4, 1'b1, 5, 16'h0064};
    tv[2] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4, 1'b0, 0, 16'hF804};
    tv[3] = '{1, 32'h07050301, 32'h08060402, 4, 1'b0, 0, 16'h0064};
    tv[4] = '{2, 32'h00000002, 32'h00000003, 1, 1'b0, 0, 16'h0006};
    tv[5] = '{2, 32'h00000004, 32'h00000005, 1, 1'b0, 0, 16'h0014};
    tv[6] = '{0, 32'h01010101, 32'h01010101, 4, 1'b0, 0, 16'h0004};
    #1 rst = 1'b1;
    #2 chk_rst("reset_values");
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rst_n_after_reset", 64'(mrn), 64'h7);
    for (int i = 0; i < 6; i++) run_job(i);
    k = 0; n = 0;
    while (k < 2 && n < 50) begin
      @(negedge clk);
      n++;
      ov[0] = 1'b1; oa[0] = 8'd9; ob[0] = 8'd9;
      if (ordy[0]) k++;
    end
    chk("midjob_pairs", 64'(k), 64'd2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_rst("midjob_reset");
    ov[0] = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    run_job(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end
endmodule

// File: doc/mac_host_seq.md
# mac_host_seq

Host-side sequencer that drives the pin-level interface of the `mac_spst_tiny` accumulator from the other end. It does four things:
- accepts operand pairs from an upstream valid/ready stream;
- clears the MAC, then issues one accumulate pulse per pair;
- turns the shared 8-bit B/high-byte bus around;
- reads the 16-bit accumulator back as one result on a downstream valid/ready stream.

One result is produced per job of LEN pairs. It sits between the test/host logic and the MAC pins.

## Interface
- `LEN`, default 4: operand pairs accumulated per job, ≥1.
- `TURN_CYC`, default 1: bus-turnaround cycles with `mac_b_oe`=0 before the readback sample, ≥1.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `op_valid` input 1: upstream operand pair valid.
- `op_ready` output 1: pair accepted when `op_valid`&`op_ready`.
- `op_a` input 8: operand A.
- `op_b` input 8: operand B.
- `res_valid` output 1: result available.
- `res_ready` input 1: downstream accepts result.
- `res_data` output 16: {high byte, low byte} of the accumulator.
- `mac_rst_n` output 1: MAC reset, active-low.
- `mac_ena` output 1: MAC accumulate enable.
- `mac_a` output 8: MAC operand A pins.
- `mac_b` output 8: MAC operand B, driven on the shared bus.
- `mac_b_oe` output 1: 1 = host drives the shared bus.
- `mac_low` input 8: MAC low byte.
- `mac_high` input 8: MAC high byte, read from the shared bus.
- `busy` output 1: high in any state except IDLE.

## Operation
- All outputs are registered.
- States: IDLE, CLEAR, ACC, DRAIN, TURN, CAPTURE, HOLD.
- IDLE:
  - Outputs: `op_ready`=0, `mac_b_oe`=0, `mac_ena`=0, `mac_rst_n`=1.
  - `op_valid`=1 → CLEAR. The pair is not consumed.
- CLEAR (1 cycle):
  - `mac_rst_n`=0, `mac_b_oe`=1, `mac_b`=0.
  - → ACC, with pair count `cnt`=0.
- ACC:
  - `op_ready`=1 while `cnt`<LEN.
  - On a handshake: `mac_a`/`mac_b` ← `op_a`/`op_b`, `mac_ena`←1 for exactly the next cycle, and `cnt`+1.
  - Without a handshake: `mac_ena`←0, `cnt` and pin values hold.
  - The handshake that makes `cnt`=LEN → DRAIN, and `op_ready`←0.
- DRAIN (1 cycle):
  - The last `mac_ena` pulse is on the pins; `mac_b_oe`=1 and B is held.
  - → TURN.
- TURN (TURN_CYC cycles):
  - `mac_b_oe`=0, `mac_ena`=0, `mac_b`←0.
  - → CAPTURE.
- CAPTURE (1 cycle):
  - `res_data` ← {`mac_high`,`mac_low`} at the end of the cycle.
  - → HOLD.
- HOLD:
  - `res_valid`=1; `res_data` is stable.
  - `res_valid`&`res_ready` → IDLE, and `res_valid`←0 on the same edge.
- `cnt` width is clog2(LEN+1). The accumulator wraps mod 2^16 inside the MAC; the host reports exactly what it reads and performs no saturation.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values: `op_ready`=0, `res_valid`=0, `res_data`=0, `mac_rst_n`=0 while `rst` is asserted and 1 after, `mac_ena`=0, `mac_a`=0, `mac_b`=0, `mac_b_oe`=0, `busy`=0; state is IDLE.
- Job start: `op_valid` rises in cycle c → CLEAR in c+1 → first `op_ready`=1 in c+2.
- With `op_valid` held high, one pair is accepted per cycle. Each `mac_ena` pulse lasts one cycle and appears one cycle after its handshake.
- Last handshake in cycle h:
  - `mac_ena` pulse in h+1 (DRAIN);
  - `mac_b_oe`=0 from h+2 through h+1+TURN_CYC;
  - sample taken in h+2+TURN_CYC;
  - `res_valid`=1 from h+3+TURN_CYC. With TURN_CYC=1 this is h+4.
- `mac_b_oe` is never 1 during TURN or CAPTURE.
- Bubbles in ACC (`op_valid`=0) insert cycles with `mac_ena`=0 and do not change the result.
- In HOLD with `res_ready` held high, `res_valid` is high for 1 cycle. A new job may start in the following IDLE cycle.
- `op_valid` during DRAIN through HOLD is ignored (`op_ready`=0).
- `rst` mid-job aborts immediately to reset values. The partial accumulation is discarded, and the next job begins with CLEAR.
- With LEN=1, ACC accepts exactly one pair, then goes to DRAIN.

## Test plan
- Basic job: LEN=4, TURN_CYC=1, behavioural MAC model, pairs (1,2),(3,4),(5,6),(7,8) back-to-back → `res_data`=0x0064, with `res_valid` rising 4 cycles after the last handshake.
- Bubbles: same pairs with `op_valid` toggling every cycle → `res_data`=0x0064; exactly 4 `mac_ena` cycles; `cnt` holds across gaps.
- Backpressure and second job:
  - Hold `res_ready`=0 for 5 cycles → `res_valid`/`res_data` stable and `op_ready`=0 throughout.
  - Release → IDLE.
  - Second job of (255,255)×4 → `mac_rst_n` low for 1 cycle, then `res_data`=0xF804 (wrap).
- Reset mid-job: assert `rst` after 2 of 4 pairs → all outputs go to reset values asynchronously. The next job (1,1)×4 → `res_data`=0x0004.
- Turnaround check: TURN_CYC=3 → `mac_b_oe`=0 for exactly 3 cycles before CAPTURE. No cycle has `mac_b_oe`=1 while the model drives `mac_high`.
- Back-to-back jobs: LEN=1, `res_ready` held high, pairs (2,3) then (4,5) → results 0x0006 then 0x0014, each preceded by a CLEAR cycle.
